// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the fetch port, the load/store port and the memory-side bus of
//   the instruction/data memory arbiter into one interface.
//
//   Parameters:
//     XLEN          data and address width
//
//   Signal groups:
//     Fetch (I)     IReq, IAdr -> arbiter; IDone, IReadData <- arbiter
//     Load/store(D) DReq, DWE, DByteEn, DAdr, DWriteData -> arbiter;
//                   DDone, DReadData <- arbiter
//     Memory        MemEn, MemWE, MemByteEn, MemAdr, MemWriteData <- arbiter;
//                   MemReadData, MemReady -> arbiter
//     Status        BusErr <- arbiter
//
//   Modports:
//     slave         the arbiter itself
//     master        the surrounding datapath/memory (or a testbench)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int XLEN = 32
);

  // Instruction fetch side
  logic            IReq;
  logic [XLEN-1:0] IAdr;
  logic            IDone;
  logic [XLEN-1:0] IReadData;

  // Load/store side
  logic            DReq;
  logic            DWE;
  logic [3:0]      DByteEn;
  logic [XLEN-1:0] DAdr;
  logic [XLEN-1:0] DWriteData;
  logic            DDone;
  logic [XLEN-1:0] DReadData;

  // Memory side
  logic            MemEn;
  logic            MemWE;
  logic [3:0]      MemByteEn;
  logic [XLEN-1:0] MemAdr;
  logic [XLEN-1:0] MemWriteData;
  logic [XLEN-1:0] MemReadData;
  logic            MemReady;

  // Sticky timeout flag
  logic            BusErr;

  modport slave (
    input  IReq, IAdr,
    input  DReq, DWE, DByteEn, DAdr, DWriteData,
    input  MemReadData, MemReady,
    output IDone, IReadData,
    output DDone, DReadData,
    output MemEn, MemWE, MemByteEn, MemAdr, MemWriteData,
    output BusErr
  );

  modport master (
    output IReq, IAdr,
    output DReq, DWE, DByteEn, DAdr, DWriteData,
    output MemReadData, MemReady,
    input  IDone, IReadData,
    input  DDone, DReadData,
    input  MemEn, MemWE, MemByteEn, MemAdr, MemWriteData,
    input  BusErr
  );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory between instruction fetch (I) and
//   load/store (D). A granted request is registered, held on the memory bus
//   until MemReady, and then answered with a one-cycle Done pulse on the
//   owning port together with registered read data. D always wins over I
//   because it belongs to the older instruction.
//
//   Parameters:
//     XLEN            data/address width
//     TIMEOUT_CYCLES  BUSY cycles without MemReady before the access is
//                     aborted (only meaningful with ARB_TIMEOUT_EN), >= 1
//
//   Ports:
//     clk             rising-edge clock
//     reset           asynchronous, active-high reset
//     bus             mem_arbiter_if.slave (fetch, load/store, memory, BusErr)
//
//   Build option:
//     ARB_TIMEOUT_EN  when defined, a BUSY watchdog aborts stalled accesses,
//                     returns zero data with a Done pulse and sets the sticky
//                     BusErr flag. When undefined, BUSY waits forever and
//                     BusErr is tied low.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // A zero or negative watchdog limit can never be reached sensibly.
  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [XLEN-1:0] adr_q, adr_d;
  logic            we_q, we_d;
  logic [3:0]      byteEn_q, byteEn_d;
  logic [XLEN-1:0] wData_q, wData_d;
  logic [XLEN-1:0] iReadData_q, iReadData_d;
  logic [XLEN-1:0] dReadData_q, dReadData_d;

`ifdef ARB_TIMEOUT_EN
  localparam int              CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busErr_q, busErr_d;
`endif

  // State, request latch and read-data registers. Everything clears on
  // reset, so an access in flight is simply forgotten and MemEn (decoded
  // from the state) drops without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      adr_q       <= '0;
      we_q        <= 1'b0;
      byteEn_q    <= 4'b0000;
      wData_q     <= '0;
      iReadData_q <= '0;
      dReadData_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      busErr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      byteEn_q    <= byteEn_d;
      wData_q     <= wData_d;
      iReadData_q <= iReadData_d;
      dReadData_q <= dReadData_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      busErr_q    <= busErr_d;
`endif
    end
  end

  // Next-state logic. Requests are only looked at in IDLE; anything that
  // arrives while an access is outstanding waits for the next IDLE cycle.
  // The request fields are latched on the grant so the memory bus stays
  // constant for the whole BUSY phase even if the requester misbehaves.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    adr_d       = adr_q;
    we_d        = we_q;
    byteEn_d    = byteEn_q;
    wData_d     = wData_q;
    iReadData_d = iReadData_q;
    dReadData_d = dReadData_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    busErr_d    = busErr_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.DReq) begin
          // Byte enables and write data only matter for stores; loads put
          // zeros on the bus.
          owner_d  = OWN_D;
          adr_d    = bus.DAdr;
          we_d     = bus.DWE;
          byteEn_d = bus.DWE ? bus.DByteEn : 4'b0000;
          wData_d  = bus.DWE ? bus.DWriteData : '0;
          state_d  = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else if (bus.IReq) begin
          owner_d  = OWN_I;
          adr_d    = bus.IAdr;
          we_d     = 1'b0;
          byteEn_d = 4'b0000;
          wData_d  = '0;
          state_d  = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end

      BUSY: begin
        // MemReady is checked before the watchdog so a completion on the
        // last allowed cycle is still a clean completion.
        if (bus.MemReady) begin
          if (owner_q == OWN_I) begin
            iReadData_d = bus.MemReadData;
          end else begin
            dReadData_d = we_q ? '0 : bus.MemReadData;
          end
          state_d = RESP;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          if (owner_q == OWN_I) begin
            iReadData_d = '0;
          end else begin
            dReadData_d = '0;
          end
          busErr_d = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs. Enables are qualified with BUSY so a stale store never
  // looks like a write while MemEn is low; address and data just show the
  // last latched request.
  always_comb begin
    bus.MemEn        = (state_q == BUSY);
    bus.MemWE        = (state_q == BUSY) && we_q;
    bus.MemByteEn    = (state_q == BUSY) ? byteEn_q : 4'b0000;
    bus.MemAdr       = adr_q;
    bus.MemWriteData = wData_q;
    bus.IDone        = (state_q == RESP) && (owner_q == OWN_I);
    bus.DDone        = (state_q == RESP) && (owner_q == OWN_D);
    bus.IReadData    = iReadData_q;
    bus.DReadData    = dReadData_q;
`ifdef ARB_TIMEOUT_EN
    bus.BusErr       = busErr_q;
`else
    bus.BusErr       = 1'b0;
`endif
  end

endmodule
